mc_mainfsm: RTL and testbench

Main control state machine for the multicycle ARM core. Each instruction is sequenced through fetch, decode, execute, memory and writeback states over a single shared instruction/data memory port, with variable memory latency handled by a req/ready handshake. Outputs are the unconditioned strobes (RegW, MemW, Branch) and datapath selects. Condition gating and ALU function decode stay in the existing condlogic/decode logic.

---
 rtl/mc_mainfsm_pkg.sv | 43 ++++
 rtl/mc_mainfsm_outdec.sv | 101 ++++++++++
 rtl/mc_mainfsm.sv | 143 ++++++++++++++
 tb/tb_mc_mainfsm.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_mainfsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Purpose  : Shared types and encodings for the multicycle main control FSM:
//             state enum, datapath select encodings and instruction op codes.
//  Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } mc_state_e;

    // alu_src_a encodings
    localparam logic [1:0] SRCA_RD1      = 2'd0;
    localparam logic [1:0] SRCA_PC       = 2'd1;

    // alu_src_b encodings
    localparam logic [1:0] SRCB_RD2      = 2'd0;
    localparam logic [1:0] SRCB_EXTIMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR     = 2'd2;

    // result_src encodings
    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

    // Instr[27:26] op classes
    localparam logic [1:0] OP_DP         = 2'b00;
    localparam logic [1:0] OP_MEM        = 2'b01;
    localparam logic [1:0] OP_BR         = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_mainfsm_outdec.sv
`default_nettype none
// ============================================================================
//  Module   : mc_mainfsm_outdec
//  Purpose  : Combinational Moore output decode for the main control FSM.
//             ir_write/next_pc additionally qualify on mem_ready in FETCH.
//  Config   : MC_MAINFSM_BL_EN adds link_w, asserted in BRANCH for BL.
//  Revision : 1.0  initial release
// ============================================================================
module mc_mainfsm_outdec
    import mc_pkg::*;
(
    input  mc_state_e  state,
    input  logic       mem_ready,
`ifdef MC_MAINFSM_BL_EN
    input  logic       funct4,
    output logic       link_w,
`endif
    output logic       mem_req,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch
);

    // Per-state output decode; every output defaults to 0 first
    always_comb begin
        mem_req    = 1'b0;
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        result_src = RES_ALUOUT;
        alu_op     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
`ifdef MC_MAINFSM_BL_EN
        link_w     = 1'b0;
`endif
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                ir_write   = mem_ready;
                next_pc    = mem_ready;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            DECODE: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            EXECUTER: begin
                alu_op     = 1'b1;
            end
            EXECUTEI: begin
                alu_src_b  = SRCB_EXTIMM;
                alu_op     = 1'b1;
            end
            ALUWB: begin
                reg_w      = 1'b1;
            end
            MEMADR: begin
                alu_src_b  = SRCB_EXTIMM;
            end
            MEMRD: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            MEMWR: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                mem_w      = 1'b1;
            end
            BRANCH: begin
                alu_src_b  = SRCB_EXTIMM;
                result_src = RES_ALURESULT;
                branch     = 1'b1;
`ifdef MC_MAINFSM_BL_EN
                link_w     = funct4;
`endif
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_mainfsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_mainfsm
//  Purpose  : Main control state machine of the multicycle ARM core. Sequences
//             fetch/decode/execute/memory/writeback over a shared memory port
//             with a req/ready handshake, and counts retired instructions.
//  Config   : MC_MAINFSM_BL_EN adds the link_w output (BL writes R14).
//  Revision : 1.0  initial release
// ============================================================================
module mc_mainfsm
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  op,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        ir_write,
    output logic        next_pc,
    output logic        adr_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic        alu_op,
    output logic        reg_w,
    output logic        mem_w,
    output logic        branch,
    output logic        illegal,
`ifdef MC_MAINFSM_BL_EN
    output logic        link_w,
`endif
    output logic [31:0] instret
);

    mc_state_e   r_state;
    mc_state_e   w_next_state;
    logic        w_retire;
    logic [31:0] r_instret;

    logic        w_mem_req;
    logic        w_ir_write;
    logic        w_next_pc;
    logic        w_reg_w;
    logic        w_mem_w;
    logic        w_branch;
    logic        w_unused_funct;

`ifdef MC_MAINFSM_BL_EN
    logic        w_link_w;
    assign w_unused_funct = ^funct[3:1];
`else
    assign w_unused_funct = ^funct[4:1];
`endif

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next_state;
    end

    // Next-state logic and retire detection
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        case (r_state)
            FETCH:    if (mem_ready) w_next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_DP:   w_next_state = funct[5] ? EXECUTEI : EXECUTER;
                    OP_MEM:  w_next_state = MEMADR;
                    OP_BR:   w_next_state = BRANCH;
                    default: w_next_state = FETCH;
                endcase
            end
            EXECUTER: w_next_state = ALUWB;
            EXECUTEI: w_next_state = ALUWB;
            ALUWB: begin
                w_next_state = FETCH;
                w_retire     = 1'b1;
            end
            MEMADR:   w_next_state = funct[0] ? MEMRD : MEMWR;
            MEMRD:    if (mem_ready) w_next_state = MEMWB;
            MEMWB: begin
                w_next_state = FETCH;
                w_retire     = 1'b1;
            end
            MEMWR: begin
                if (mem_ready) begin
                    w_next_state = FETCH;
                    w_retire     = 1'b1;
                end
            end
            BRANCH: begin
                w_next_state = FETCH;
                w_retire     = 1'b1;
            end
            default:  w_next_state = FETCH;
        endcase
    end

    // Retired-instruction counter, wraps naturally at 32 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_instret <= 32'd0;
        else if (w_retire) r_instret <= r_instret + 32'd1;
    end

    mc_mainfsm_outdec u_outdec (
        .state      (r_state),
        .mem_ready  (mem_ready),
`ifdef MC_MAINFSM_BL_EN
        .funct4     (funct[4]),
        .link_w     (w_link_w),
`endif
        .mem_req    (w_mem_req),
        .ir_write   (w_ir_write),
        .next_pc    (w_next_pc),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .reg_w      (w_reg_w),
        .mem_w      (w_mem_w),
        .branch     (w_branch)
    );

    // Strobes are gated by reset so nothing fires while reset is asserted;
    // selects need no gating because the state is already forced to FETCH.
    assign mem_req  = w_mem_req  & ~reset;
    assign ir_write = w_ir_write & ~reset;
    assign next_pc  = w_next_pc  & ~reset;
    assign reg_w    = w_reg_w    & ~reset;
    assign mem_w    = w_mem_w    & ~reset;
    assign branch   = w_branch   & ~reset;
    assign illegal  = (r_state == DECODE) && (op == 2'b11) && !reset;
`ifdef MC_MAINFSM_BL_EN
    assign link_w   = w_link_w   & ~reset;
`endif
    assign instret  = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mc_mainfsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_mainfsm
//  Purpose  : Self-checking bench for mc_mainfsm. Directed instruction
//             sequences push per-cycle expected outputs into a queue; a
//             monitor pops and compares them every cycle.
//  Config   : MC_MAINFSM_BL_EN connects and checks link_w.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_mainfsm;
    import mc_pkg::*;

    localparam int C_TIMEOUT_CYCLES = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  op = 2'b00;
    logic [5:0]  funct = 6'b000000;
    logic        mem_ready = 1'b0;
    logic        mem_req, ir_write, next_pc, adr_src;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic        alu_op, reg_w, mem_w, branch, illegal;
    logic [31:0] instret;
    logic        link_v;
`ifdef MC_MAINFSM_BL_EN
    logic        link_w;
    assign link_v = link_w;
`else
    assign link_v = 1'b0;
`endif

    mc_mainfsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .ir_write   (ir_write),
        .next_pc    (next_pc),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .branch     (branch),
        .illegal    (illegal),
`ifdef MC_MAINFSM_BL_EN
        .link_w     (link_w),
`endif
        .instret    (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] o;
        logic [31:0] n;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic        done = 1'b0;
    logic [31:0] exp_instret = 32'd0;
    string       tname = "RESET";

    // Expected outputs from the state table, packed as
    // {mem_req,ir_write,next_pc,adr_src,a[1:0],b[1:0],res[1:0],alu_op,reg_w,mem_w,branch,illegal,link_w}
    function automatic logic [15:0] model(mc_state_e s, logic mr, logic rst);
        logic mq = 1'b0, irw = 1'b0, npc = 1'b0, adr = 1'b0, aop = 1'b0;
        logic rw = 1'b0, mw = 1'b0, br = 1'b0, ill = 1'b0, lk = 1'b0;
        logic [1:0] a = 2'd0, b = 2'd0, r = 2'd0;
        if (rst) begin
            a = 2'd1; b = 2'd2; r = 2'd2;
        end else begin
            case (s)
                FETCH:    begin mq = 1'b1; irw = mr; npc = mr; a = 2'd1; b = 2'd2; r = 2'd2; end
                DECODE:   begin a = 2'd1; b = 2'd2; r = 2'd2; ill = (op == 2'b11); end
                EXECUTER: begin aop = 1'b1; end
                EXECUTEI: begin b = 2'd1; aop = 1'b1; end
                ALUWB:    begin rw = 1'b1; end
                MEMADR:   begin b = 2'd1; end
                MEMRD:    begin mq = 1'b1; adr = 1'b1; end
                MEMWB:    begin r = 2'd1; rw = 1'b1; end
                MEMWR:    begin mq = 1'b1; adr = 1'b1; mw = 1'b1; end
                BRANCH: begin
                    b = 2'd1; r = 2'd2; br = 1'b1;
`ifdef MC_MAINFSM_BL_EN
                    lk = funct[4];
`endif
                end
                default: begin end
            endcase
        end
        return {mq, irw, npc, adr, a, b, r, aop, rw, mw, br, ill, lk};
    endfunction

    function automatic void push(mc_state_e s, logic mr, logic rst);
        exp_t e;
        e.o   = model(s, mr, rst);
        e.n   = exp_instret;
        e.tag = {tname, ":", (rst ? "RST" : s.name())};
        q.push_back(e);
    endfunction

    // One cycle with reset low in the named state
    task automatic cyc(input mc_state_e s, input logic mr);
        @(posedge clk); #1;
        reset     = 1'b0;
        mem_ready = mr;
        push(s, mr, 1'b0);
        if (s == ALUWB || s == MEMWB || s == BRANCH || (s == MEMWR && mr))
            exp_instret = exp_instret + 32'd1;
    endtask

    // First FETCH cycle of a new instruction
    task automatic fetch(input string nm, input logic [1:0] o, input logic [5:0] f, input logic mr);
        @(posedge clk); #1;
        tname     = nm;
        reset     = 1'b0;
        op        = o;
        funct     = f;
        mem_ready = mr;
        push(FETCH, mr, 1'b0);
    endtask

    // One cycle with reset asserted; mem_ready held high to provoke strobes
    task automatic rst_cyc();
        @(posedge clk); #1;
        reset       = 1'b1;
        mem_ready   = 1'b1;
        exp_instret = 32'd0;
        push(FETCH, 1'b1, 1'b1);
    endtask

    // Monitor: compare DUT outputs against the queue head each cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] got;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {mem_req, ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
                   alu_op, reg_w, mem_w, branch, illegal, link_v};
            checks = checks + 1;
            if (got !== e.o || instret !== e.n) begin
                errors = errors + 1;
                $display("FAIL %s: got out=%b instret=%h, want out=%b instret=%h",
                         e.tag, got, instret, e.o, e.n);
            end
        end else if (done) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // Watchdog: the directed sequence must complete within a bounded time
    initial begin
        repeat (C_TIMEOUT_CYCLES) @(posedge clk);
        if (!done) begin
            errors = errors + 1;
            $display("FAIL TIMEOUT: sequence did not finish within %0d cycles",
                     C_TIMEOUT_CYCLES);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        rst_cyc();
        rst_cyc();

        // Direct reset-state check while reset is held
        checks = checks + 1;
        if (mem_req !== 1'b0 || ir_write !== 1'b0 || next_pc !== 1'b0 ||
            reg_w !== 1'b0 || mem_w !== 1'b0 || branch !== 1'b0 ||
            illegal !== 1'b0 || link_v !== 1'b0 || adr_src !== 1'b0 ||
            alu_src_a !== 2'd1 || alu_src_b !== 2'd2 || result_src !== 2'd2 ||
            instret !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL RESETSTATE: mem_req=%b ir_write=%b next_pc=%b reg_w=%b mem_w=%b branch=%b illegal=%b adr_src=%b a=%0d b=%0d res=%0d instret=%h",
                     mem_req, ir_write, next_pc, reg_w, mem_w, branch, illegal,
                     adr_src, alu_src_a, alu_src_b, result_src, instret);
        end

        // ADD register form
        fetch("ADDR", 2'b00, 6'b001000, 1'b1);
        cyc(DECODE, 1'b0);
        cyc(EXECUTER, 1'b1);
        cyc(ALUWB, 1'b0);

        // ADD immediate form
        fetch("ADDI", 2'b00, 6'b101000, 1'b1);
        cyc(DECODE, 1'b1);
        cyc(EXECUTEI, 1'b1);
        cyc(ALUWB, 1'b1);

        // LDR with 2 FETCH waits and 3 MEMRD waits: 10 cycles
        fetch("LDR", 2'b01, 6'b011001, 1'b0);
        cyc(FETCH, 1'b0);
        cyc(FETCH, 1'b1);
        cyc(DECODE, 1'b1);
        cyc(MEMADR, 1'b1);
        cyc(MEMRD, 1'b0);
        cyc(MEMRD, 1'b0);
        cyc(MEMRD, 1'b0);
        cyc(MEMRD, 1'b1);
        cyc(MEMWB, 1'b1);

        // STR with one MEMWR wait
        fetch("STR", 2'b01, 6'b011000, 1'b1);
        cyc(DECODE, 1'b1);
        cyc(MEMADR, 1'b0);
        cyc(MEMWR, 1'b0);
        cyc(MEMWR, 1'b1);

        // Illegal op: pulse in DECODE, back to FETCH, no retire
        fetch("ILL", 2'b11, 6'b000000, 1'b1);
        cyc(DECODE, 1'b1);

        // Plain branch
        fetch("B", 2'b10, 6'b100000, 1'b1);
        cyc(DECODE, 1'b1);
        cyc(BRANCH, 1'b1);

        // Branch with link
        fetch("BL", 2'b10, 6'b010000, 1'b1);
        cyc(DECODE, 1'b1);
        cyc(BRANCH, 1'b1);
        fetch("POSTBL", 2'b00, 6'b001000, 1'b0);

        // Reset in MEMWR aborts the store
        fetch("STRRST", 2'b01, 6'b011000, 1'b1);
        cyc(DECODE, 1'b1);
        cyc(MEMADR, 1'b1);
        cyc(MEMWR, 1'b0);
        rst_cyc();
        rst_cyc();
        fetch("AFTRST", 2'b00, 6'b001000, 1'b0);
        cyc(FETCH, 1'b1);
        cyc(DECODE, 1'b1);
        cyc(EXECUTER, 1'b1);
        cyc(ALUWB, 1'b1);

        // Preload instret near the top and wrap it with two branches
        @(posedge clk); #1;
        force dut.r_instret = 32'hFFFF_FFFE;
        tname       = "WRAP";
        op          = 2'b10;
        funct       = 6'b100000;
        mem_ready   = 1'b0;
        exp_instret = 32'hFFFF_FFFE;
        push(FETCH, 1'b0, 1'b0);
        #6;
        release dut.r_instret;
        cyc(FETCH, 1'b1);
        cyc(DECODE, 1'b1);
        cyc(BRANCH, 1'b1);
        fetch("WRAP2", 2'b10, 6'b100000, 1'b1);
        cyc(DECODE, 1'b1);
        cyc(BRANCH, 1'b1);
        fetch("WRAPEND", 2'b00, 6'b001000, 1'b0);

        @(posedge clk); #1;
        done = 1'b1;
    end

endmodule
`default_nettype wire
